uart_tx_resp_fifo: RTL and testbench

Response buffer and TX handshake engine in the REF_CLK domain, between the system controller's response path and the REF→UART_TX data synchronizer.
- Accepts 1- or 2-byte responses from the controller, e.g. an 8-bit register read or a 16-bit ALU result.
- Queues the bytes and launches them one at a time to the UART transmitter.
- Paces each launch on the synchronized TX busy flag, so the controller never stalls on UART busy.

---
 rtl/uart_tx_resp_fifo_pkg.sv | 14 +
 rtl/uart_tx_resp_fifo_mem.sv | 30 +++
 rtl/uart_tx_resp_fifo.sv | 133 +++++++++++++
 tb/tb_uart_tx_resp_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_resp_fifo_pkg.sv
// Shared types and defaults for the UART TX response buffer.
package uart_tx_resp_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_ACK_TIMEOUT = 64;

endpackage

// File: rtl/uart_tx_resp_fifo_mem.sv
// Response byte storage: two writes per cycle at consecutive addresses, combinational read.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  we_lo,
  input  logic                  we_hi,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata_lo,
  input  logic [DATA_WIDTH-1:0] wdata_hi,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      waddr_hi;

  // Upper byte lands one slot later, wrapping with the pointer width.
  assign waddr_hi = waddr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (we_lo) mem[waddr]    <= wdata_lo;
    if (we_hi) mem[waddr_hi] <= wdata_hi;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_resp_fifo.sv
// Queues 1/2-byte controller responses and launches them one byte at a time,
// paced on the synchronized UART TX busy flag.
//   state      | meaning
//   ST_IDLE    | waiting for a queued byte and TX not busy
//   ST_LAUNCH  | TX_VLD high, byte on TX_DATA
//   ST_WAIT_HI | waiting for TX_BUSY rise (ack timer running)
//   ST_WAIT_LO | waiting for TX_BUSY fall, then pop
module uart_tx_resp_fifo
  import uart_tx_resp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PTR_W       = $clog2(DEPTH),
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WR_EN,
  input  logic                    WR_TWO,
  input  logic [2*DATA_WIDTH-1:0] WR_DATA,
  output logic                    WR_RDY,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VLD,
  input  logic                    TX_BUSY,
  output logic [PTR_W:0]          COUNT,
  output logic                    EMPTY,
  output logic                    OVERFLOW,
  output logic                    TIMEOUT_ERR
);

  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT);

  tx_state_e             state, next_state;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      free_cnt, need, push_n;
  logic [TMR_W-1:0]      tmr;
  logic [DATA_WIDTH-1:0] head;
  logic                  accept, pop, launch, expire;

  // Space is judged on the pre-cycle count, so a same-cycle pop never helps a write.
  assign free_cnt = CNT_W'(DEPTH) - COUNT;
  assign need     = WR_TWO ? CNT_W'(2) : CNT_W'(1);
  assign accept   = WR_EN && (free_cnt >= need);
  assign push_n   = accept ? need : '0;
  assign WR_RDY   = free_cnt >= CNT_W'(2);
  assign EMPTY    = (COUNT == '0) && (state == ST_IDLE);

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk     (CLK),
    .we_lo   (accept),
    .we_hi   (accept && WR_TWO),
    .waddr   (wr_ptr),
    .wdata_lo(WR_DATA[DATA_WIDTH-1:0]),
    .wdata_hi(WR_DATA[2*DATA_WIDTH-1:DATA_WIDTH]),
    .raddr   (rd_ptr),
    .rdata   (head)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + need[PTR_W-1:0];
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      COUNT <= COUNT + push_n - CNT_W'(pop);
      if (WR_EN && !accept) OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    expire     = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((COUNT != '0) && !TX_BUSY) begin
          launch     = 1'b1;
          next_state = ST_LAUNCH;
        end
      end
      ST_LAUNCH: next_state = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (TX_BUSY) begin
          next_state = ST_WAIT_LO;
        end else if (tmr == '0) begin
          expire     = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!TX_BUSY) begin
          pop        = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  // Ack timer counts down from launch; zero in WAIT_HI means the rise never came.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      TX_VLD      <= 1'b0;
      TX_DATA     <= '0;
      TIMEOUT_ERR <= 1'b0;
      tmr         <= '0;
    end else begin
      TX_VLD      <= launch;
      TIMEOUT_ERR <= expire;
      if (launch) begin
        TX_DATA <= head;
        tmr     <= TMR_W'(ACK_TIMEOUT - 1);
      end else if (tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_resp_fifo.sv
// Directed bench for uart_tx_resp_fifo: scoreboard of expected TX bytes checked by a monitor.
module tb_uart_tx_resp_fifo;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WR_EN = 1'b0;
  logic        WR_TWO = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic        TX_BUSY = 1'b0;
  logic        WR_RDY, TX_VLD, EMPTY, OVERFLOW, TIMEOUT_ERR;
  logic [7:0]  TX_DATA;
  logic [3:0]  COUNT;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  bit         hold_busy = 1'b0;
  bit         respond   = 1'b1;
  int         rise_cnt  = 0;
  int         fall_cnt  = 0;
  bit         outstanding = 1'b0;
  bit         prev_busy   = 1'b0;
  logic [7:0] cur_byte = '0;

  uart_tx_resp_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .PTR_W      (3),
    .ACK_TIMEOUT(64)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_EN      (WR_EN),
    .WR_TWO     (WR_TWO),
    .WR_DATA    (WR_DATA),
    .WR_RDY     (WR_RDY),
    .TX_DATA    (TX_DATA),
    .TX_VLD     (TX_VLD),
    .TX_BUSY    (TX_BUSY),
    .COUNT      (COUNT),
    .EMPTY      (EMPTY),
    .OVERFLOW   (OVERFLOW),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // UART transmitter model: busy rises 3 cycles after a launch and falls 10 cycles later.
  always @(negedge CLK) begin
    if (!RST) begin
      rise_cnt = 0;
      fall_cnt = 0;
      TX_BUSY  = hold_busy;
    end else if (hold_busy) begin
      TX_BUSY = 1'b1;
    end else if (TX_VLD && respond) begin
      rise_cnt = 3;
    end else if (rise_cnt != 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        TX_BUSY  = 1'b1;
        fall_cnt = 10;
      end
    end else if (fall_cnt != 0) begin
      fall_cnt--;
      if (fall_cnt == 0) TX_BUSY = 1'b0;
    end else begin
      TX_BUSY = 1'b0;
    end
  end

  // Monitor: every launch must match the scoreboard head, be spaced after the
  // previous busy fall (or timeout), and hold TX_DATA steady while in flight.
  always @(posedge CLK) begin
    #2;
    if (!RST) begin
      outstanding = 1'b0;
    end else begin
      if (TIMEOUT_ERR) outstanding = 1'b0;
      if (prev_busy && !TX_BUSY) outstanding = 1'b0;
      if (outstanding) check("tx_data_stable", TX_DATA, cur_byte);
      if (TX_VLD) begin
        check("launch_spacing", outstanding, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra actual=0x%0h required=none", TX_DATA);
        end else begin
          check("tx_byte", TX_DATA, exp_q.pop_front());
        end
        outstanding = 1'b1;
        cur_byte    = TX_DATA;
      end
    end
    prev_busy = TX_BUSY;
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic write(input bit two, input logic [15:0] d, input bit exp_ok);
    if (exp_ok) begin
      exp_q.push_back(d[7:0]);
      if (two) exp_q.push_back(d[15:8]);
    end
    WR_EN   = 1'b1;
    WR_TWO  = two;
    WR_DATA = d;
    tick();
    WR_EN   = 1'b0;
    WR_TWO  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && !(COUNT == 0 && EMPTY); i++) tick();
    check({name, "_count"}, COUNT, 0);
    check({name, "_empty"}, EMPTY, 1);
    check({name, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int c;
    bit found;
    bit prev;

    // 1: reset, then a single byte
    RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    check("reset_count", COUNT, 0);
    check("reset_empty", EMPTY, 1);
    check("reset_wr_rdy", WR_RDY, 1);
    check("reset_tx_vld", TX_VLD, 0);
    check("reset_overflow", OVERFLOW, 0);
    write(1'b0, 16'h00A5, 1'b1);
    check("t1_count", COUNT, 1);
    drain("t1", 200);

    // 2: 16-bit result goes out LSB first
    write(1'b1, 16'h1234, 1'b1);
    check("t2_count", COUNT, 2);
    drain("t2", 200);

    // 3: fill with TX busy, then reject a 2-byte write
    hold_busy = 1'b1;
    tick();
    tick();
    write(1'b1, 16'hA1B2, 1'b1);
    write(1'b1, 16'hC3D4, 1'b1);
    write(1'b1, 16'hE5F6, 1'b1);
    check("t3_count6", COUNT, 6);
    check("t3_wr_rdy6", WR_RDY, 1);
    write(1'b1, 16'h0718, 1'b1);
    check("t3_count8", COUNT, 8);
    check("t3_wr_rdy8", WR_RDY, 0);
    check("t3_no_launch", EMPTY, 0);
    write(1'b1, 16'hBEEF, 1'b0);
    check("t3_count_after_reject", COUNT, 8);
    check("t3_overflow", OVERFLOW, 1);
    hold_busy = 1'b0;
    drain("t3", 400);

    // 4: stream 20 bytes with wrap, one push landing on a pop cycle
    for (int b = 1; b <= 20; b++) begin
      if (b == 10) begin
        prev  = TX_BUSY;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
          tick();
          if (prev && !TX_BUSY) begin
            found = 1'b1;
            break;
          end
          prev = TX_BUSY;
        end
        check("t4_fall_seen", found, 1);
        c = COUNT;
        write(1'b0, 16'(b), 1'b1);
        check("t4_push_pop_count", COUNT, c);
      end else begin
        for (int i = 0; i < 100 && !WR_RDY; i++) tick();
        check("t4_wr_rdy", WR_RDY, 1);
        write(1'b0, 16'(b), 1'b1);
      end
    end
    drain("t4", 600);

    // 5: no ack -> timeout, relaunch of the same byte, single pop
    respond = 1'b0;
    write(1'b0, 16'h005A, 1'b1);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < 20 && !TX_VLD; i++) tick();
    check("t5_launch", TX_VLD, 1);
    t0 = cyc;
    tick();
    for (int i = 0; i < 100 && !TIMEOUT_ERR; i++) tick();
    check("t5_timeout_seen", TIMEOUT_ERR, 1);
    respond = 1'b1;
    check("t5_timeout_cycle", cyc - t0, 64);
    check("t5_count", COUNT, 1);
    tick();
    check("t5_pulse_width", TIMEOUT_ERR, 0);
    check("t5_relaunch", TX_VLD, 1);
    drain("t5", 200);

    // 6: reset while in WAIT_LO with three bytes held
    write(1'b0, 16'h0061, 1'b1);
    write(1'b0, 16'h0062, 1'b1);
    write(1'b0, 16'h0063, 1'b1);
    for (int i = 0; i < 50 && !TX_BUSY; i++) tick();
    check("t6_busy", TX_BUSY, 1);
    tick();
    tick();
    check("t6_count", COUNT, 3);
    check("t6_overflow_sticky", OVERFLOW, 1);
    RST = 1'b0;
    exp_q.delete();
    tick();
    check("t6_count_rst", COUNT, 0);
    check("t6_tx_data_rst", TX_DATA, 0);
    check("t6_overflow_rst", OVERFLOW, 0);
    check("t6_tx_vld_rst", TX_VLD, 0);
    check("t6_empty_rst", EMPTY, 1);
    check("t6_wr_rdy_rst", WR_RDY, 1);
    RST = 1'b1;
    repeat (40) tick();
    check("t6_quiet_count", COUNT, 0);
    check("final_sb", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
